// File: rtl/adder_io_pkg.sv
// Shared types for the GPIO adder sequencer.
// Holds the FSM encoding and default widths.
package adder_io_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int SETTLE_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } state_t;
endpackage

// File: rtl/adder_io_sequencer_sync2.sv
// Two-flop synchroniser for asynchronous pad inputs.
// Async active-low reset clears both stages.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/adder_io_sequencer.sv
// Sequences GPIO operands into a combinational adder.
// Captures sum/carry into registered pad outputs.
module adder_io_sequencer
  import adder_io_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic [WIDTH-1:0] pin_a_i,
  input  logic [WIDTH-1:0] pin_b_i,
  input  logic             pin_stb_i,
  output logic [WIDTH-1:0] add_a_o,
  output logic [WIDTH-1:0] add_b_o,
  input  logic [WIDTH-1:0] add_sum_i,
  input  logic             add_co_i,
  output logic [WIDTH-1:0] res_sum_o,
  output logic             res_co_o,
  output logic             res_valid_o,
  output logic             busy_o,
  output logic             dropped_o,
  output logic [CNT_W-1:0] op_count_o
);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST =
    SETTLE_W'(SETTLE_CYC - 1);

  logic [WIDTH-1:0]    a_s, b_s;
  logic                stb_s, stb_q, stb_edge;
  logic [SETTLE_W-1:0] cnt;
  logic                load, cap, drop;
  state_t              state, state_n;

  sync2 #(.W(WIDTH)) u_sync_a (
    .clk(wb_clk_i), .rst_n(wb_rst_ni), .d(pin_a_i), .q(a_s)
  );
  sync2 #(.W(WIDTH)) u_sync_b (
    .clk(wb_clk_i), .rst_n(wb_rst_ni), .d(pin_b_i), .q(b_s)
  );
  sync2 #(.W(1)) u_sync_stb (
    .clk(wb_clk_i), .rst_n(wb_rst_ni), .d(pin_stb_i), .q(stb_s)
  );

  assign stb_edge = stb_s & ~stb_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state  <= IDLE;
      busy_o <= 1'b0;
    end else begin
      state  <= state_n;
      busy_o <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (stb_edge) state_n = SETTLE;
      SETTLE:  if (cnt == SETTLE_LAST) state_n = CAPTURE;
      CAPTURE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    load = 1'b0;
    cap  = 1'b0;
    drop = 1'b0;
    unique case (state)
      IDLE:    load = stb_edge;
      SETTLE:  drop = stb_edge;
      CAPTURE: begin
        drop = stb_edge;
        cap  = 1'b1;
      end
      default: ;
    endcase
  end

  // Operands and results hold until an accepted strobe or a capture.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      stb_q       <= 1'b0;
      cnt         <= '0;
      add_a_o     <= '0;
      add_b_o     <= '0;
      res_sum_o   <= '0;
      res_co_o    <= 1'b0;
      res_valid_o <= 1'b0;
      dropped_o   <= 1'b0;
      op_count_o  <= '0;
    end else begin
      stb_q <= stb_s;
      if (load) begin
        add_a_o     <= a_s;
        add_b_o     <= b_s;
        res_valid_o <= 1'b0;
        cnt         <= '0;
      end else if (state == SETTLE) begin
        cnt <= cnt + 1'b1;
      end
      if (cap) begin
        res_sum_o   <= add_sum_i;
        res_co_o    <= add_co_i;
        res_valid_o <= 1'b1;
        op_count_o  <= op_count_o + 1'b1;
      end
      if (drop) dropped_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_adder_io_sequencer.sv
// Scoreboard bench for adder_io_sequencer.
// Two instances (8-bit and 2-bit op counters) share stimulus.
module tb_adder_io_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] pin_a = '0, pin_b = '0;
  logic       pin_stb = 1'b0;

  logic [3:0] a0, b0, s0, rs0, a1, b1, s1, rs1;
  logic       c0, rc0, rv0, bz0, dr0, c1, rc1, rv1, bz1, dr1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;

  always #5 clk = ~clk;

  assign {c0, s0} = {1'b0, a0} + {1'b0, b0};
  assign {c1, s1} = {1'b0, a1} + {1'b0, b1};

  adder_io_sequencer #(.WIDTH(4), .SETTLE_CYC(2), .CNT_W(8)) u_dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .pin_a_i(pin_a), .pin_b_i(pin_b), .pin_stb_i(pin_stb),
    .add_a_o(a0), .add_b_o(b0), .add_sum_i(s0), .add_co_i(c0),
    .res_sum_o(rs0), .res_co_o(rc0), .res_valid_o(rv0),
    .busy_o(bz0), .dropped_o(dr0), .op_count_o(cnt0)
  );

  adder_io_sequencer #(.WIDTH(4), .SETTLE_CYC(2), .CNT_W(2)) u_dut2 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .pin_a_i(pin_a), .pin_b_i(pin_b), .pin_stb_i(pin_stb),
    .add_a_o(a1), .add_b_o(b1), .add_sum_i(s1), .add_co_i(c1),
    .res_sum_o(rs1), .res_co_o(rc1), .res_valid_o(rv1),
    .busy_o(bz1), .dropped_o(dr1), .op_count_o(cnt1)
  );

  typedef struct {
    int sum;
    int co;
    int cnt8;
    int cnt2;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_ops = 0;
  logic rv_q = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every rising res_valid must match the oldest outstanding op.
  always @(negedge clk) begin
    if (rv0 && !rv_q) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got sum %0d with no op pending", rs0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_sum", int'(rs0), e.sum);
        chk("res_co", int'(rc0), e.co);
        chk("op_count8", int'(cnt0), e.cnt8);
        chk("op_count2", int'(cnt1), e.cnt2);
        chk("res_sum2", int'(rs1), e.sum);
        chk("res_valid2", int'(rv1), 1);
      end
    end
    rv_q = rv0;
  end

  task automatic push_exp(input int a, input int b);
    exp_t e;
    n_ops++;
    e.sum  = (a + b) % 16;
    e.co   = (a + b) / 16;
    e.cnt8 = n_ops % 256;
    e.cnt2 = n_ops % 4;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bz0 && rv0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL timeout: got busy %0d valid %0d expected idle+valid", bz0, rv0);
    end
  endtask

  task automatic do_op(input int a, input int b, input int hold);
    @(negedge clk);
    pin_a = 4'(a);
    pin_b = 4'(b);
    pin_stb = 1'b1;
    push_exp(a, b);
    repeat (3) @(posedge clk);
    #1;
    chk("add_a", int'(a0), a);
    chk("add_b", int'(b0), b);
    chk("busy", int'(bz0), 1);
    chk("valid_cleared", int'(rv0), 0);
    if (hold > 3) repeat (hold - 3) @(negedge clk);
    @(negedge clk);
    pin_stb = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int ra, rb;
    repeat (3) @(negedge clk);
    chk("rst_sum", int'(rs0), 0);
    chk("rst_valid", int'(rv0), 0);
    chk("rst_busy", int'(bz0), 0);
    chk("rst_count", int'(cnt0), 0);
    chk("rst_add_a", int'(a0), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    do_op(5, 3, 1);
    do_op(15, 1, 1);
    do_op(15, 15, 2);
    do_op(9, 6, 20);
    chk("no_drop_held", int'(dr0), 0);

    // Second strobe edge lands while the first op is settling.
    @(negedge clk);
    pin_a = 4'd7;
    pin_b = 4'd2;
    pin_stb = 1'b1;
    push_exp(7, 2);
    @(negedge clk);
    pin_stb = 1'b0;
    @(negedge clk);
    pin_a = 4'd1;
    pin_b = 4'd1;
    pin_stb = 1'b1;
    @(negedge clk);
    pin_stb = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);
    chk("drop_add_a", int'(a0), 7);
    chk("drop_add_b", int'(b0), 2);
    chk("dropped", int'(dr0), 1);
    do_op(4, 4, 1);
    chk("dropped_sticky", int'(dr0), 1);

    // Reset while settling: no capture may follow.
    @(negedge clk);
    pin_a = 4'd3;
    pin_b = 4'd12;
    pin_stb = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    pin_stb = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_add_a", int'(a0), 0);
    chk("mid_rst_busy", int'(bz0), 0);
    chk("mid_rst_sum", int'(rs0), 0);
    chk("mid_rst_drop", int'(dr0), 0);
    chk("mid_rst_count", int'(cnt0), 0);
    n_ops = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_busy", int'(bz0), 0);
    chk("post_rst_valid", int'(rv0), 0);
    chk("post_rst_count", int'(cnt0), 0);

    for (int i = 0; i < 24; i++) begin
      ra = int'($urandom_range(0, 15));
      rb = int'($urandom_range(0, 15));
      do_op(ra, rb, int'($urandom_range(1, 6)));
    end
    chk("sb_empty", sb.size(), 0);
    chk("final_count", int'(cnt0), n_ops % 256);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
